// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI register-file responder.
package spi_responder_pkg;

    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;
    localparam int DIR_WRITE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

endpackage

// File: rtl/spi_responder_if.sv
// SPI pin bundle between an external master and the responder.
interface spi_responder_if;

    logic spi_sclk;
    logic spi_ss_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk,
        output spi_ss_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sclk,
        input  spi_ss_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall
// detection from the last two synchronized samples.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    // Presetting to the pin's idle level keeps reset release from looking like an edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_last <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_last;
    assign o_fall  = ~o_level & r_last;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: a command byte selects a register address and
// direction, following data bytes burst-write or burst-read a 32x8 file.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    spi_responder_if.slave    spi,
    input  logic [7:0]        status_in,
    input  logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              abort_pulse
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_async (spi.spi_sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_async (spi.spi_ss_n),
        .o_level (w_ss_level),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_async (spi.spi_mosi),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_level, w_ss_level, w_mosi_rise, w_mosi_fall};

    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_rx;
    logic [7:0]        r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_dir;
    logic              r_miso_oe;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_abort;
    logic [7:0]        r_regs [REG_COUNT];

    logic [7:0]        w_rx_next;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_rx_next  = {r_rx[6:0], w_mosi};
    assign w_addr_inc = r_addr + 5'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_addr     <= '0;
            r_dir      <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_abort    <= 1'b0;
            // NOTE: the register file is cleared on reset, so it must stay in flops, not RAM.
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_valid <= 1'b0;
            r_abort    <= 1'b0;
            if (w_ss_rise) begin
                r_state   <= ST_IDLE;
                r_miso_oe <= 1'b0;
                r_bit_cnt <= '0;
                if (r_bit_cnt != 3'd0) begin
                    r_abort <= 1'b1;
                end
            end else if (w_ss_fall) begin
                // A coincident SCLK rise is the first bit of the command byte.
                r_state   <= ST_CMD;
                r_miso_oe <= 1'b1;
                r_tx      <= status_in;
                if (w_sclk_rise) begin
                    r_rx      <= w_rx_next;
                    r_bit_cnt <= 3'd1;
                end else begin
                    r_bit_cnt <= 3'd0;
                end
            end else if (r_state != ST_IDLE) begin
                if (w_sclk_rise) begin
                    r_rx      <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_state == ST_CMD) begin
                            r_state <= ST_DATA;
                            r_addr  <= w_rx_next[7:3];
                            r_dir   <= w_rx_next[DIR_WRITE];
                            r_tx    <= w_rx_next[DIR_WRITE] ? 8'h00 : r_regs[w_rx_next[7:3]];
                        end else if (r_dir) begin
                            r_regs[r_addr] <= w_rx_next;
                            r_wr_valid     <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_wr_data      <= w_rx_next;
                            r_addr         <= w_addr_inc;
                            r_tx           <= 8'h00;
                        end else begin
                            r_addr <= w_addr_inc;
                            r_tx   <= r_regs[w_addr_inc];
                        end
                    end
                end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    assign spi.spi_miso    = r_miso_oe ? r_tx[7] : 1'b0;
    assign spi.spi_miso_oe = r_miso_oe;
    assign rf_rdata        = r_regs[rf_addr];
    assign wr_valid        = r_wr_valid;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign busy            = (r_state != ST_IDLE);
    assign abort_pulse     = r_abort;

endmodule
